fifo_uart_tx: RTL and testbench

//  Drains bytes from the 16x8 byte FIFO and serializes them on a UART line.

---
 rtl/fifo_uart_tx_pkg.sv | 23 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 29 ++
 rtl/fifo_uart_tx.sv | 108 ++++++++++
 tb/tb_fifo_uart_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and frame constants.
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud-rate divider: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear,
// tick marks the last clock of each bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt_reg <= '0;
    end else if (clear || (baud_cnt_reg == CNT_LAST)) begin
      baud_cnt_reg <= '0;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
    end
  end

  assign tick = !clear && (baud_cnt_reg == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream registered-read FIFO
// and serializes them LSB first with a fixed integer baud divider.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              fifo_r_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t                state_reg, state_next;
  logic [DATA_W-1:0]     shift_reg, shift_next;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg;
  logic                  tx_done_reg;
  logic                  baud_clear;
  logic                  baud_tick;

  // Divider is held at zero until the frame starts so START gets a full bit period.
  assign baud_clear = (state_reg == IDLE) || (state_reg == FETCH);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  assign fifo_r_en = (state_reg == IDLE) && !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        shift_next   = fifo_r_data;
        bit_cnt_next = '0;
        state_next   = START;
      end
      START: begin
        if (baud_tick) state_next = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          if (bit_cnt_reg == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_tick) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so tx comes straight off a flop.
  always_comb begin
    tx_next = STOP_BIT;
    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
      default: tx_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= STOP_BIT;
      busy_reg    <= 1'b0;
      tx_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      busy_reg    <= (state_next != IDLE);
      tx_done_reg <= (state_reg == STOP) && baud_tick;
    end
  end

  assign tx      = tx_reg;
  assign busy    = busy_reg;
  assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural 16x8 FIFO upstream, UART line monitor
// decoding frames against a queue of bytes written into the FIFO.
module tb_fifo_uart_tx;

  localparam int CPB        = 4;
  localparam int FRAME_CYC  = 10 * CPB;
  localparam int PERIOD_CYC = 10 * CPB + 2;
  localparam int BUSY_CYC   = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_r_data = 8'h00;
  logic       fifo_r_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_r_en  (fifo_r_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // ---------------- upstream FIFO model (registered read) ----------------
  logic [7:0] fifo_mem [16];
  int         fifo_cnt = 0;
  int         fifo_wp = 0;
  int         fifo_rp = 0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  int         underflows = 0;
  int         overflows = 0;
  logic       do_rd;
  logic       do_wr;

  assign fifo_empty = (fifo_cnt == 0);
  assign do_rd = fifo_r_en && (fifo_cnt != 0);
  assign do_wr = wr_en && (fifo_cnt != 16);

  always @(posedge clk) begin
    if (fifo_r_en && fifo_cnt == 0) underflows <= underflows + 1;
    if (wr_en && fifo_cnt == 16) overflows <= overflows + 1;
    if (do_rd) begin
      fifo_r_data <= fifo_mem[fifo_rp];
      fifo_rp     <= (fifo_rp + 1) % 16;
    end
    if (do_wr) begin
      fifo_mem[fifo_wp] <= wr_data;
      fifo_wp           <= (fifo_wp + 1) % 16;
    end
    fifo_cnt <= fifo_cnt + int'(do_wr) - int'(do_rd);
  end

  // ---------------- event counters ----------------
  int cyc = 0;
  int ren_count = 0;
  int done_count = 0;
  int busy_run = 0;
  int busy_lens [$];
  int start_cyc [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) ren_count <= ren_count + 1;
    if (tx_done) done_count <= done_count + 1;
  end

  always @(negedge clk) begin
    if (busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      busy_lens.push_back(busy_run);
      busy_run <= 0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, expv, $time);
    end
  endtask

  // Flow-control invariants checked every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("ren_when_empty", 32'(fifo_r_en & fifo_empty), 0);
        check("ren_when_busy", 32'(fifo_r_en & busy), 0);
      end
    end
  end

  // Line monitor: on each start edge pop the expected byte and check every cycle of the frame.
  initial begin
    logic       last_tx;
    logic [9:0] bits;
    logic [7:0] expb;
    bit         aborted;
    int         frame_idx;
    last_tx = 1'b1;
    frame_idx = 0;
    forever begin
      @(negedge clk);
      if (reset && last_tx == 1'b1 && tx == 1'b0) begin
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          expb = 8'h00;
        end else begin
          expb = exp_q.pop_front();
        end
        bits = {1'b1, expb, 1'b0};
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!reset) aborted = 1'b1;
            else check($sformatf("frame%0d_byte%02h_bit%0d", frame_idx, expb, b), 32'(tx), 32'(bits[b]));
          end
        end
        if (!aborted) begin
          @(negedge clk);
          if (reset) check($sformatf("frame%0d_tx_done", frame_idx), 32'(tx_done), 1);
        end
        frame_idx++;
      end
      last_tx = tx;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fifo_write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_reached", 32'(done_count >= target), 1);
  endtask

  task automatic wait_start(input int nframes, input int budget);
    int n;
    n = 0;
    while (start_cyc.size() <= nframes && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_start_reached", 32'(start_cyc.size() > nframes), 1);
  endtask

  task automatic check_periods(input string tag, input int first, input int n);
    check({tag, "_frames"}, start_cyc.size() - first, n);
    for (int i = first + 1; i < first + n && i < start_cyc.size(); i++)
      check(tag, start_cyc[i] - start_cyc[i-1], PERIOD_CYC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int base_ren, base_done, base_fr, s, n;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ren", 32'(fifo_r_en), 0);
    check("rst_done", 32'(tx_done), 0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single byte
    base_ren = ren_count; base_done = done_count; base_fr = start_cyc.size();
    busy_lens.delete();
    fifo_write(8'hA5);
    wait_done(base_done + 1, 200);
    repeat (3) @(negedge clk);
    check("s1_ren_pulses", ren_count - base_ren, 1);
    check("s1_done_pulses", done_count - base_done, 1);
    check("s1_frames", start_cyc.size() - base_fr, 1);
    check("s1_busy_len", (busy_lens.size() > 0) ? busy_lens[0] : 0, BUSY_CYC);

    // 2: back-to-back
    base_ren = ren_count; base_done = done_count; base_fr = start_cyc.size();
    busy_lens.delete();
    fifo_write(8'h00);
    fifo_write(8'hFF);
    fifo_write(8'h3C);
    wait_done(base_done + 3, 400);
    repeat (3) @(negedge clk);
    check("s2_ren_pulses", ren_count - base_ren, 3);
    check("s2_done_pulses", done_count - base_done, 3);
    check_periods("s2_period", base_fr, 3);
    check("s2_busy_runs", busy_lens.size(), 3);
    foreach (busy_lens[i]) check("s2_busy_len", busy_lens[i], BUSY_CYC);

    // 3: empty hold-off
    base_ren = ren_count;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("s3_tx_idle", 32'(tx), 1);
      check("s3_busy_low", 32'(busy), 0);
      check("s3_ren_low", 32'(fifo_r_en), 0);
    end
    check("s3_ren_pulses", ren_count - base_ren, 0);
    check("s3_underflow", underflows, 0);

    // 4: full FIFO drain
    base_ren = ren_count; base_done = done_count; base_fr = start_cyc.size();
    for (int i = 0; i < 16; i++) fifo_write(8'(i));
    n = 0;
    while (ren_count < base_ren + 16 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("s4_fetches_reached", 32'(ren_count >= base_ren + 16), 1);
    check("s4_empty_after_last_fetch", 32'(fifo_empty), 1);
    wait_done(base_done + 16, 1000);
    repeat (3) @(negedge clk);
    check("s4_done_pulses", done_count - base_done, 16);
    check("s4_ren_pulses", ren_count - base_ren, 16);
    check_periods("s4_period", base_fr, 16);
    check("s4_overflow", overflows, 0);

    // 6: write during STOP of the current frame
    base_ren = ren_count; base_done = done_count; base_fr = start_cyc.size();
    fifo_write(8'h96);
    wait_start(base_fr, 100);
    s = (start_cyc.size() > base_fr) ? start_cyc[base_fr] : cyc;
    while (cyc < s + FRAME_CYC - CPB + 1) @(negedge clk);
    check("s6_in_stop_tx", 32'(tx), 1);
    check("s6_in_stop_busy", 32'(busy), 1);
    fifo_write(8'h4B);
    check("s6_ren_in_stop", 32'(fifo_r_en), 0);
    wait_done(base_done + 2, 300);
    repeat (3) @(negedge clk);
    check("s6_ren_pulses", ren_count - base_ren, 2);
    check_periods("s6_period", base_fr, 2);

    // 5: reset during DATA bit 3
    base_done = done_count; base_fr = start_cyc.size();
    fifo_write(8'h81);
    wait_start(base_fr, 100);
    s = (start_cyc.size() > base_fr) ? start_cyc[base_fr] : cyc;
    while (cyc < s + CPB + 3 * CPB + 2) @(negedge clk);
    check("s5_bit3_value", 32'(tx), 0);
    #2 reset = 1'b0;
    #1;
    check("s5_rst_tx", 32'(tx), 1);
    check("s5_rst_busy", 32'(busy), 0);
    check("s5_rst_ren", 32'(fifo_r_en), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s5_rst_no_done", 32'(tx_done), 0);
    end
    #2 reset = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check("s5_no_done_after_abort", done_count - base_done, 0);
    check("s5_lost_byte_not_pending", exp_q.size(), 0);
    check("s5_line_idle", 32'(tx), 1);
    base_fr = start_cyc.size();
    fifo_write(8'h5A);
    wait_done(base_done + 1, 200);
    repeat (3) @(negedge clk);
    check("s5_next_frame", start_cyc.size() - base_fr, 1);
    check("s5_done_pulses", done_count - base_done, 1);

    check("end_queue_empty", exp_q.size(), 0);
    check("end_underflow", underflows, 0);
    check("end_overflow", overflows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
